// File: rtl/uart_wb8_pkg.sv
//------------------------------------------------------------------------------
// Package : uart_wb8_pkg
// Register map, status bit index and host FSM encoding for uart_wb8 access.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none
package uart_wb8_pkg;

  localparam logic [1:0] UART_ADR_DATA   = 2'd0;
  localparam logic [1:0] UART_ADR_RXSTAT = 2'd1;
  localparam logic [1:0] UART_ADR_TXSTAT = 2'd2;
  localparam int         UART_STAT_BIT   = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TXSTAT = 3'd1,
    ST_TXWR   = 3'd2,
    ST_RXSTAT = 3'd3,
    ST_RXRD   = 3'd4
  } host_state_t;

  function automatic logic [1:0] state_adr(input host_state_t s);
    logic [1:0] a;
    a = UART_ADR_DATA;
    case (s)
      ST_TXSTAT: a = UART_ADR_TXSTAT;
      ST_RXSTAT: a = UART_ADR_RXSTAT;
      default:   a = UART_ADR_DATA;
    endcase
    return a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_ack_timeout.sv
//------------------------------------------------------------------------------
// Module : wb_ack_timeout
// Counts strobe-high cycles without ACK; flags expiry on the TIMEOUT-th cycle.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none
module wb_ack_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_stb,
  input  logic i_ack,
  output logic o_expire
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || !i_stb || i_ack) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_stb & ~i_ack & (r_cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_wb8_host.sv
//------------------------------------------------------------------------------
// Module : uart_wb8_host
// Wishbone classic master bridging TX/RX byte streams to a uart_wb8 slave.
// Option : define UART_WB8_HOST_TIMEOUT_EN for the ACK timeout / O_err pulse.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none
module uart_wb8_host
  import uart_wb8_pkg::*;
#(
  parameter int POLL_GAP = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  output logic [1:0] ADR_O,
  output logic [7:0] DAT_O,
  input  logic [7:0] DAT_I,
  output logic       STB_O,
  output logic       WE_O,
  input  logic       ACK_I,
  input  logic [7:0] I_tx_data,
  input  logic       I_tx_valid,
  output logic       O_tx_ready,
  output logic [7:0] O_rx_data,
  output logic       O_rx_valid,
  input  logic       I_rx_ready,
  output logic       O_err
);

  localparam logic [7:0] GAP = 8'(POLL_GAP);

  host_state_t r_state, w_state_nx;
  logic [7:0]  r_gap;
  logic        r_last_rx;
  logic        r_stb, r_we;
  logic [1:0]  r_adr;
  logic [7:0]  r_dat;
  logic        r_tx_ready;
  logic [7:0]  r_tx_data;
  logic        r_rx_valid;
  logic [7:0]  r_rx_data;
  logic        w_ack, w_abort, w_tx_elig, w_rx_elig, w_stat;

  assign w_ack     = r_stb & ACK_I;
  assign w_tx_elig = ~r_tx_ready;
  assign w_rx_elig = ~r_rx_valid;
  assign w_stat    = DAT_I[UART_STAT_BIT];

`ifdef UART_WB8_HOST_TIMEOUT_EN
  logic r_err;

  wb_ack_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk      (CLK_I),
    .rst      (RST_I),
    .i_stb    (r_stb),
    .i_ack    (ACK_I),
    .o_expire (w_abort)
  );

  always_ff @(posedge CLK_I) begin
    if (RST_I) r_err <= 1'b0;
    else       r_err <= w_abort;
  end

  assign O_err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_abort          = 1'b0;
  assign O_err            = 1'b0;
`endif

  // r_last_rx=1 after reset so TX wins the first tie.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_gap == GAP) begin
          if (w_tx_elig && (!w_rx_elig || r_last_rx)) w_state_nx = ST_TXSTAT;
          else if (w_rx_elig)                         w_state_nx = ST_RXSTAT;
        end
      end
      ST_TXSTAT: if (w_ack) w_state_nx = w_stat ? ST_IDLE : ST_TXWR;
      ST_TXWR:   if (w_ack) w_state_nx = ST_IDLE;
      ST_RXSTAT: if (w_ack) w_state_nx = w_stat ? ST_RXRD : ST_IDLE;
      ST_RXRD:   if (w_ack) w_state_nx = ST_IDLE;
      default:   w_state_nx = ST_IDLE;
    endcase
    if (w_abort) w_state_nx = ST_IDLE;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state    <= ST_IDLE;
      r_gap      <= 8'd0;
      r_last_rx  <= 1'b1;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_adr      <= 2'd0;
      r_dat      <= 8'd0;
      r_tx_ready <= 1'b1;
      r_tx_data  <= 8'd0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'd0;
    end else begin
      r_state <= w_state_nx;

      if (r_state == ST_IDLE && w_state_nx != ST_IDLE) begin
        r_gap     <= 8'd0;
        r_last_rx <= (w_state_nx == ST_RXSTAT);
      end else if (r_state == ST_IDLE && r_gap != GAP) begin
        r_gap <= r_gap + 8'd1;
      end

      // Strobe rises one cycle after entering a bus state and falls after ACK.
      if (r_stb) begin
        if (ACK_I || w_abort) begin
          r_stb <= 1'b0;
          r_we  <= 1'b0;
        end
      end else if (r_state != ST_IDLE) begin
        r_stb <= 1'b1;
        r_adr <= state_adr(r_state);
        r_we  <= (r_state == ST_TXWR);
        if (r_state == ST_TXWR) r_dat <= r_tx_data;
      end

      if (I_tx_valid && r_tx_ready) begin
        r_tx_data  <= I_tx_data;
        r_tx_ready <= 1'b0;
      end else if (r_state == ST_TXWR && w_ack) begin
        r_tx_ready <= 1'b1;
      end

      if (r_rx_valid && I_rx_ready) begin
        r_rx_valid <= 1'b0;
      end else if (r_state == ST_RXRD && w_ack) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= DAT_I;
      end
    end
  end

  assign ADR_O      = r_adr;
  assign DAT_O      = r_dat;
  assign STB_O      = r_stb;
  assign WE_O       = r_we;
  assign O_tx_ready = r_tx_ready;
  assign O_rx_data  = r_rx_data;
  assign O_rx_valid = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_uart_wb8_host.sv
//------------------------------------------------------------------------------
// Module : tb_uart_wb8_host
// Bench for uart_wb8_host with a behavioural uart_wb8 responder and scoreboards.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none
module tb_uart_wb8_host;

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b1;
  logic [1:0] ADR_O;
  logic [7:0] DAT_O;
  logic [7:0] DAT_I;
  logic       STB_O, WE_O, ACK_I;
  logic [7:0] I_tx_data  = 8'h00;
  logic       I_tx_valid = 1'b0;
  logic       O_tx_ready;
  logic [7:0] O_rx_data;
  logic       O_rx_valid;
  logic       I_rx_ready = 1'b0;
  logic       O_err;

  always #5 CLK_I = ~CLK_I;

  uart_wb8_host dut (
    .CLK_I      (CLK_I),
    .RST_I      (RST_I),
    .ADR_O      (ADR_O),
    .DAT_O      (DAT_O),
    .DAT_I      (DAT_I),
    .STB_O      (STB_O),
    .WE_O       (WE_O),
    .ACK_I      (ACK_I),
    .I_tx_data  (I_tx_data),
    .I_tx_valid (I_tx_valid),
    .O_tx_ready (O_tx_ready),
    .O_rx_data  (O_rx_data),
    .O_rx_valid (O_rx_valid),
    .I_rx_ready (I_rx_ready),
    .O_err      (O_err)
  );

  // Responder: a UART with a TX-busy countdown (per status read) and an RX byte queue.
  localparam byte unsigned JT = 8'h54;
  localparam byte unsigned JR = 8'h52;

  bit           ack_en   = 1'b1;
  bit           stall_wr = 1'b0;
  int           tx_busy  = 0;
  byte unsigned rx_q[$];
  byte unsigned wr_log[$];
  byte unsigned got_rx[$];
  byte unsigned jobs[$];
  int           n_txstat = 0;
  int           n_rxstat = 0;
  bit           last_busy = 1'b1;
  logic [7:0]   resp_dat = 8'h00;
  logic [6:0]   junk = 7'h55;

  int n_vec = 0;
  int n_err = 0;

  assign DAT_I = resp_dat;
  assign ACK_I = STB_O & ack_en & ~(stall_wr & WE_O);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  logic       p_valid = 1'b0, p_we;
  logic [1:0] p_adr;
  logic [7:0] p_do, p_di;
  logic       prev_stb = 1'b0, prev_ack = 1'b0, prev_rxv = 1'b0;
  logic [10:0] prev_bus;
  logic [7:0] prev_rxd;

  always @(negedge CLK_I) begin
    case (ADR_O)
      2'd0:    resp_dat = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
      2'd1:    resp_dat = {junk, rx_q.size() != 0};
      default: resp_dat = {junk, tx_busy > 0};
    endcase
    if (!RST_I) begin
      if (prev_ack) check("stb_gap", 32'(STB_O), 32'd0);
      if (prev_stb && !prev_ack && STB_O) check("stb_hold", 32'({ADR_O, WE_O, DAT_O}), 32'(prev_bus));
      if (prev_rxv && O_rx_valid) check("rx_stable", 32'(O_rx_data), 32'(prev_rxd));
      if (STB_O && ACK_I) begin
        p_valid = 1'b1; p_adr = ADR_O; p_we = WE_O; p_do = DAT_O; p_di = resp_dat;
        if (WE_O) check("tx_ready_during_wr", 32'(O_tx_ready), 32'd0);
      end
      if (O_rx_valid && I_rx_ready) got_rx.push_back(O_rx_data);
    end
    prev_ack = STB_O & ACK_I & ~RST_I;
    prev_stb = STB_O;
    prev_bus = {ADR_O, WE_O, DAT_O};
    prev_rxv = O_rx_valid & ~RST_I;
    prev_rxd = O_rx_data;
  end

  always @(posedge CLK_I) begin
    #1;
    junk = 7'($urandom);
    if (p_valid) begin
      p_valid = 1'b0;
      if (p_we) begin
        check("wr_adr", 32'(p_adr), 32'd0);
        check("wr_after_idle_stat", 32'(last_busy), 32'd0);
        check("tx_ready_after_ack", 32'(O_tx_ready), 32'd1);
        wr_log.push_back(p_do);
        last_busy = 1'b1;
      end else begin
        case (p_adr)
          2'd2: begin
            n_txstat++; jobs.push_back(JT); last_busy = p_di[0];
            if (tx_busy > 0) tx_busy--;
          end
          2'd1: begin n_rxstat++; jobs.push_back(JR); end
          2'd0: if (rx_q.size() != 0) void'(rx_q.pop_front());
          default: ;
        endcase
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int k;
    @(posedge CLK_I); #2;
    I_tx_data  = b;
    I_tx_valid = 1'b1;
    for (k = 0; k < 400; k++) begin
      @(negedge CLK_I);
      if (O_tx_ready) break;
    end
    if (!O_tx_ready) tmo("send_accept");
    @(posedge CLK_I); #1;
    I_tx_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string name);
    int k;
    for (k = 0; k < 800 && wr_log.size() < n; k++) @(negedge CLK_I);
    if (wr_log.size() < n) tmo(name);
  endtask

  task automatic wait_rx_valid(input string name);
    int k;
    for (k = 0; k < 400 && !O_rx_valid; k++) @(negedge CLK_I);
    if (!O_rx_valid) tmo(name);
  endtask

  typedef struct {
    bit         is_rx;
    logic [7:0] data;
    int         busy;
    int         exp_polls;
    logic [7:0] exp_data;
  } vec_t;

  initial begin
    vec_t         vt[7];
    byte unsigned exp_jobs[4];
    byte unsigned exp_tx[$];
    byte unsigned exp_rx[$];
    int           base, k;
    bit           stable;

    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vt[7];
    byte unsigned exp_jobs[4];
    byte unsigned exp_tx[$];
    byte unsigned exp_rx[$];
    int           base, k, hi;
    bit           stable;

    vt[0] = '{1'b0, 8'h54, 0, 1, 8'h54};
    vt[1] = '{1'b0, 8'h54, 3, 4, 8'h54};
    vt[2] = '{1'b0, 8'h00, 1, 2, 8'h00};
    vt[3] = '{1'b0, 8'hFF, 2, 3, 8'hFF};
    vt[4] = '{1'b1, 8'hA5, 0, 0, 8'hA5};
    vt[5] = '{1'b1, 8'h00, 0, 0, 8'h00};
    vt[6] = '{1'b1, 8'hFF, 0, 0, 8'hFF};
    exp_jobs[0] = JT; exp_jobs[1] = JR; exp_jobs[2] = JT; exp_jobs[3] = JR;

    // Reset values
    repeat (3) @(negedge CLK_I);
    check("rst_stb",      32'(STB_O),      32'd0);
    check("rst_we",       32'(WE_O),       32'd0);
    check("rst_adr",      32'(ADR_O),      32'd0);
    check("rst_dat",      32'(DAT_O),      32'd0);
    check("rst_tx_ready", 32'(O_tx_ready), 32'd1);
    check("rst_rx_valid", 32'(O_rx_valid), 32'd0);
    check("rst_rx_data",  32'(O_rx_data),  32'd0);
    check("rst_err",      32'(O_err),      32'd0);
    @(posedge CLK_I); #1 RST_I = 1'b0;

    // Table-driven single transfers
    for (int i = 0; i < 7; i++) begin
      if (!vt[i].is_rx) begin
        wr_log.delete();
        n_txstat = 0;
        tx_busy  = vt[i].busy;
        send_byte(vt[i].data);
        wait_writes(1, "tx_vec_write");
        repeat (12) @(negedge CLK_I);
        check("tx_vec_polls", 32'(n_txstat), 32'(vt[i].exp_polls));
        check("tx_vec_nwr", 32'(wr_log.size()), 32'd1);
        if (wr_log.size() != 0) check("tx_vec_data", 32'(wr_log[0]), 32'(vt[i].exp_data));
      end else begin
        I_rx_ready = 1'b0;
        rx_q.push_back(vt[i].data);
        wait_rx_valid("rx_vec_valid");
        check("rx_vec_data", 32'(O_rx_data), 32'(vt[i].exp_data));
        @(posedge CLK_I); #1 I_rx_ready = 1'b1;
        @(posedge CLK_I); #1 I_rx_ready = 1'b0;
        @(negedge CLK_I);
        check("rx_vec_clear", 32'(O_rx_valid), 32'd0);
      end
    end
    got_rx.delete();

    // RX holding register stays full while the client stalls
    rx_q.push_back(8'hA5);
    wait_rx_valid("rx_hold_valid");
    base   = n_rxstat;
    stable = 1'b1;
    repeat (20) begin
      @(negedge CLK_I);
      if (!(O_rx_valid && O_rx_data == 8'hA5)) stable = 1'b0;
    end
    check("rx_hold_stable", 32'(stable), 32'd1);
    check("rx_no_poll_full", 32'(n_rxstat), 32'(base));
    @(posedge CLK_I); #1 I_rx_ready = 1'b1;
    @(posedge CLK_I); #1 I_rx_ready = 1'b0;
    @(negedge CLK_I);
    check("rx_hold_clear", 32'(O_rx_valid), 32'd0);
    repeat (30) @(negedge CLK_I);
    check("rx_poll_resume", 32'(n_rxstat > base), 32'd1);
    got_rx.delete();

    // Round-robin: TX pending and RX available together from reset
    @(posedge CLK_I); #1;
    RST_I = 1'b1;
    rx_q.delete();
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    tx_busy    = 1;
    I_rx_ready = 1'b1;
    I_tx_data  = 8'h3C;
    I_tx_valid = 1'b1;
    repeat (2) @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    jobs.delete(); wr_log.delete(); got_rx.delete();
    last_busy = 1'b1;
    @(posedge CLK_I); #1 I_tx_valid = 1'b0;
    for (k = 0; k < 400 && jobs.size() < 4; k++) @(negedge CLK_I);
    if (jobs.size() < 4) tmo("rr_jobs");
    for (int j = 0; j < 4; j++)
      if (j < jobs.size()) check("rr_order", 32'(jobs[j]), 32'(exp_jobs[j]));
    wait_writes(1, "rr_write");
    for (k = 0; k < 400 && got_rx.size() < 2; k++) @(negedge CLK_I);
    if (wr_log.size() != 0) check("rr_tx_data", 32'(wr_log[0]), 32'h3C);
    check("rr_rx_count", 32'(got_rx.size()), 32'd2);
    if (got_rx.size() >= 2) begin
      check("rr_rx0", 32'(got_rx[0]), 32'h11);
      check("rr_rx1", 32'(got_rx[1]), 32'h22);
    end
    got_rx.delete();

    // Reset while a data write is strobing
    I_rx_ready = 1'b0;
    rx_q.push_back(8'h77);
    wait_rx_valid("rst_rx_fill");
    stall_wr = 1'b1;
    tx_busy  = 0;
    wr_log.delete();
    send_byte(8'hC3);
    for (k = 0; k < 400 && !(STB_O && WE_O); k++) @(negedge CLK_I);
    if (!(STB_O && WE_O)) tmo("rst_wr_strobe");
    check("wr_strobe_dat", 32'(DAT_O), 32'hC3);
    RST_I = 1'b1;
    @(posedge CLK_I); #1;
    RST_I    = 1'b0;
    stall_wr = 1'b0;
    @(negedge CLK_I);
    check("midrst_stb",      32'(STB_O),      32'd0);
    check("midrst_tx_ready", 32'(O_tx_ready), 32'd1);
    check("midrst_rx_valid", 32'(O_rx_valid), 32'd0);
    check("midrst_err",      32'(O_err),      32'd0);
    repeat (30) @(negedge CLK_I);
    check("midrst_no_write", 32'(wr_log.size()), 32'd0);
    last_busy = 1'b1;

`ifdef UART_WB8_HOST_TIMEOUT_EN
    // Silent responder: strobe is abandoned after TIMEOUT cycles and the byte retried
    for (k = 0; k < 50 && STB_O; k++) @(negedge CLK_I);
    ack_en = 1'b0;
    tx_busy = 0;
    send_byte(8'h96);
    for (k = 0; k < 100 && !STB_O; k++) @(negedge CLK_I);
    hi = 0;
    while (STB_O && hi < 100) begin
      hi++;
      @(negedge CLK_I);
    end
    check("tmo_stb_cycles", 32'(hi), 32'd16);
    check("tmo_err_pulse", 32'(O_err), 32'd1);
    @(negedge CLK_I);
    check("tmo_err_single", 32'(O_err), 32'd0);
    ack_en = 1'b1;
    wait_writes(1, "tmo_retry_write");
    if (wr_log.size() != 0) check("tmo_retry_data", 32'(wr_log[0]), 32'h96);
`endif

    // Randomized traffic against in-order scoreboards
    wr_log.delete(); got_rx.delete(); rx_q.delete();
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          logic [7:0] b;
          b = 8'($urandom);
          tx_busy = $urandom_range(0, 2);
          exp_tx.push_back(b);
          send_byte(b);
          repeat ($urandom_range(0, 5)) @(posedge CLK_I);
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          logic [7:0] b;
          repeat ($urandom_range(5, 30)) @(posedge CLK_I);
          #1;
          b = 8'($urandom);
          rx_q.push_back(b);
          exp_rx.push_back(b);
        end
      end
      begin
        for (int i = 0; i < 1500; i++) begin
          @(posedge CLK_I); #1;
          I_rx_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge CLK_I); #1 I_rx_ready = 1'b1;
    for (k = 0; k < 3000 && (wr_log.size() < exp_tx.size() || got_rx.size() < exp_rx.size()); k++)
      @(negedge CLK_I);
    check("rand_tx_count", 32'(wr_log.size()), 32'(exp_tx.size()));
    check("rand_rx_count", 32'(got_rx.size()), 32'(exp_rx.size()));
    for (int i = 0; i < exp_tx.size() && i < wr_log.size(); i++)
      check("rand_tx_seq", 32'(wr_log[i]), 32'(exp_tx[i]));
    for (int i = 0; i < exp_rx.size() && i < got_rx.size(); i++)
      check("rand_rx_seq", 32'(got_rx[i]), 32'(exp_rx[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
